alu_seq: RTL and testbench

Parametrised, multicycle-capable ALU for the multicycle RISC datapath. It supports ADD, NAND, SUB/compare and an iterative shift-add multiply. It holds the architectural carry/zero flags internally and evaluates the ADC/ADZ/NDC/NDZ write conditions itself. A valid/ready handshake sits between the control FSM and the ALU, so the controller can issue single-cycle ops back-to-back and stall only on multiply.

---
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 132 +++++++++++++
 tb/tb_alu_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control FSM and alu_seq.
// The controller is the master; the ALU drives results and flags back.
interface alu_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [1:0]       cond;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             wr_en;
   logic             eq;
   logic             neg;
   logic             flag_c;
   logic             flag_z;

   modport master (
      output in_valid, op, cond, in1, in2,
      input  in_ready, out, out_valid, wr_en, eq, neg, flag_c, flag_z
   );

   modport slave (
      input  in_valid, op, cond, in1, in2,
      output in_ready, out, out_valid, wr_en, eq, neg, flag_c, flag_z
   );
endinterface

// File: rtl/alu_seq.sv
// Multicycle-capable ALU: single-cycle ADD/NAND/SUB, iterative shift-add MUL,
// architectural carry/zero flags and conditional write-enable evaluation.
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   alu_seq_if.slave   bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {OP_ADD, OP_NAND, OP_SUB, OP_MUL} op_t;
   typedef enum logic {IDLE, MUL} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic               mul_met;
   logic               mul_eq;

   logic               cond_met;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic [2*WIDTH-1:0] mul_step;

   assign bus.in_ready = (state == IDLE);
   assign sum          = {1'b0, bus.in1} + {1'b0, bus.in2};
   assign mul_step     = mplier[0] ? acc + mcand : acc;

   // Flags seen here are the registered values, so the previous op's result
   // is already visible without forwarding.
   always_comb begin
      case (bus.cond)
         2'b00:   cond_met = 1'b1;
         2'b01:   cond_met = bus.flag_z;
         2'b10:   cond_met = bus.flag_c;
         default: cond_met = 1'b0;
      endcase
   end

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and a latch is never inferred.
   always_comb begin
      alu_res = '0;
      alu_c   = bus.flag_c;
      case (op_t'(bus.op))
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
         end
         OP_NAND: alu_res = ~(bus.in1 & bus.in2);
         OP_SUB: begin
            alu_res = bus.in1 - bus.in2;
            alu_c   = (bus.in1 >= bus.in2);
         end
         default: ;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         acc           <= '0;
         mcand         <= '0;
         mplier        <= '0;
         mul_met       <= 1'b0;
         mul_eq        <= 1'b0;
         bus.out       <= '0;
         bus.out_valid <= 1'b0;
         bus.wr_en     <= 1'b0;
         bus.eq        <= 1'b0;
         bus.neg       <= 1'b0;
         bus.flag_c    <= 1'b0;
         bus.flag_z    <= 1'b0;
      end else begin
         bus.out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (op_t'(bus.op) == OP_MUL) begin
                     mcand   <= {{WIDTH{1'b0}}, bus.in1};
                     mplier  <= bus.in2;
                     acc     <= '0;
                     cnt     <= '0;
                     mul_met <= cond_met;
                     mul_eq  <= (bus.in1 == bus.in2);
                     state   <= MUL;
                  end else begin
                     bus.out       <= alu_res;
                     bus.out_valid <= 1'b1;
                     bus.wr_en     <= cond_met;
                     bus.eq        <= (bus.in1 == bus.in2);
                     bus.neg       <= alu_res[WIDTH-1];
                     if (cond_met) begin
                        bus.flag_c <= alu_c;
                        bus.flag_z <= (alu_res == '0);
                     end
                  end
               end
            end
            MUL: begin
               acc    <= mul_step;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  bus.out       <= mul_step[WIDTH-1:0];
                  bus.out_valid <= 1'b1;
                  bus.wr_en     <= mul_met;
                  bus.eq        <= mul_eq;
                  bus.neg       <= mul_step[WIDTH-1];
                  if (mul_met) begin
                     bus.flag_c <= |mul_step[2*WIDTH-1:WIDTH];
                     bus.flag_z <= (mul_step[WIDTH-1:0] == '0);
                  end
                  cnt   <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a vector table of back-to-back single-cycle ops,
// then hand-written MUL, busy-ignore and reset sequences.
module tb_alu_seq;

   localparam int W = 16;

   logic clk;
   logic reset;
   int   n_cmp  = 0;
   int   n_fail = 0;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [1:0]   cond;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_out;
      logic         exp_wr;
      logic         exp_eq;
      logic         exp_neg;
      logic         exp_c;
      logic         exp_z;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] cond,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      bus.in_valid = v;
      bus.op       = op;
      bus.cond     = cond;
      bus.in1      = a;
      bus.in2      = b;
   endtask

   // Issue a MUL from IDLE, pulse in_valid while busy, and check latency,
   // busy duration and the registered result.
   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] cond,
                          input logic [W-1:0] exp_out, input logic exp_wr, input logic exp_eq,
                          input logic exp_c, input logic exp_z);
      int  n    = 0;
      int  busy = 0;
      bit  done = 0;
      @(negedge clk);
      drive(1'b1, 2'b11, cond, a, b);
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.out_valid) begin
            done = 1;
            bus.in_valid = 1'b0;
         end else begin
            if (!bus.in_ready) busy++;
            drive((n % 3) == 1, 2'b00, 2'b00, 16'h1111, 16'h2222);
         end
      end
      if (!done) begin
         check("mul_timeout", 32'd0, 32'd1);
      end else begin
         check("mul_latency", n, W + 1);
         check("mul_busy_cycles", busy, W);
         check("mul_ready_after", bus.in_ready, 1'b1);
         check("mul_out", bus.out, exp_out);
         check("mul_wr_en", bus.wr_en, exp_wr);
         check("mul_eq", bus.eq, exp_eq);
         check("mul_neg", bus.neg, exp_out[W-1]);
         check("mul_flag_c", bus.flag_c, exp_c);
         check("mul_flag_z", bus.flag_z, exp_z);
      end
      @(negedge clk);
      check("mul_pulse_len", bus.out_valid, 1'b0);
   endtask

   initial begin
      vecs[0]  = '{2'b00, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[1]  = '{2'b01, 2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[2]  = '{2'b00, 2'b00, 16'h0001, 16'h0001, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{2'b00, 2'b10, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{2'b00, 2'b01, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{2'b10, 2'b00, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{2'b00, 2'b01, 16'h0003, 16'h0004, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{2'b10, 2'b00, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{2'b00, 2'b11, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{2'b10, 2'b10, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{2'b01, 2'b00, 16'h00F0, 16'h0F0F, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{2'b10, 2'b00, 16'h0007, 16'h0002, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{2'b00, 2'b10, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

      reset = 1'b1;
      drive(1'b0, 2'b00, 2'b00, '0, '0);
      repeat (2) @(negedge clk);
      check("rst_out", bus.out, 16'h0000);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_wr_en", bus.wr_en, 1'b0);
      check("rst_eq", bus.eq, 1'b0);
      check("rst_neg", bus.neg, 1'b0);
      check("rst_flag_c", bus.flag_c, 1'b0);
      check("rst_flag_z", bus.flag_z, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      reset = 1'b0;

      // Back-to-back single-cycle ops; flags carry from one vector to the next.
      for (int i = 0; i < 13; i++) begin
         drive(1'b1, vecs[i].op, vecs[i].cond, vecs[i].a, vecs[i].b);
         @(negedge clk);
         check($sformatf("v%0d_out_valid", i), bus.out_valid, 1'b1);
         check($sformatf("v%0d_in_ready", i), bus.in_ready, 1'b1);
         check($sformatf("v%0d_out", i), bus.out, vecs[i].exp_out);
         check($sformatf("v%0d_wr_en", i), bus.wr_en, vecs[i].exp_wr);
         check($sformatf("v%0d_eq", i), bus.eq, vecs[i].exp_eq);
         check($sformatf("v%0d_neg", i), bus.neg, vecs[i].exp_neg);
         check($sformatf("v%0d_flag_c", i), bus.flag_c, vecs[i].exp_c);
         check($sformatf("v%0d_flag_z", i), bus.flag_z, vecs[i].exp_z);
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("idle_out_valid", bus.out_valid, 1'b0);

      // Flags are C=0, Z=0 here.
      run_mul(16'h0100, 16'h0100, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1);
      run_mul(16'h00FF, 16'h0003, 2'b00, 16'h02FD, 1'b1, 1'b0, 1'b0, 1'b0);
      run_mul(16'hFFFF, 16'hFFFF, 2'b01, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);

      // Set both flags, then abort a MUL with reset.
      drive(1'b1, 2'b00, 2'b00, 16'hFFFF, 16'h0001);
      @(negedge clk);
      check("pre_abort_flag_c", bus.flag_c, 1'b1);
      check("pre_abort_flag_z", bus.flag_z, 1'b1);
      drive(1'b1, 2'b11, 2'b00, 16'h1234, 16'h0002);
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int n = 1; n < 8; n++) begin
         check($sformatf("abort_busy%0d", n), {bus.in_ready, bus.out_valid}, 2'b00);
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_out_valid", bus.out_valid, 1'b0);
      check("abort_flag_c", bus.flag_c, 1'b0);
      check("abort_flag_z", bus.flag_z, 1'b0);
      check("abort_in_ready", bus.in_ready, 1'b1);
      @(negedge clk);
      check("abort_no_late_valid", bus.out_valid, 1'b0);

      // Reset wins over a simultaneous request.
      reset = 1'b1;
      drive(1'b1, 2'b00, 2'b00, 16'h0001, 16'h0001);
      @(negedge clk);
      reset = 1'b0;
      check("rst_req_out_valid", bus.out_valid, 1'b0);
      check("rst_req_out", bus.out, 16'h0000);

      drive(1'b1, 2'b00, 2'b00, 16'h0002, 16'h0003);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("fresh_out_valid", bus.out_valid, 1'b1);
      check("fresh_out", bus.out, 16'h0005);
      check("fresh_wr_en", bus.wr_en, 1'b1);
      check("fresh_flags", {bus.flag_c, bus.flag_z}, 2'b00);
      @(negedge clk);
      check("fresh_pulse_len", bus.out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
